// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse scheduler: config field codes, CTRL layout,
// scanner/channel state encodings and the time-of-day +1 s helper.
package pulse_sched_pkg;

  localparam logic [1:0] CFG_CTRL   = 2'd0;
  localparam logic [1:0] CFG_WIDTH  = 2'd1;
  localparam logic [1:0] CFG_PERIOD = 2'd2;
  localparam logic [1:0] CFG_COUNT  = 2'd3;

  localparam int CTRL_EN_BIT   = 31;
  localparam int CTRL_HOUR_LSB = 16;
  localparam int CTRL_HOUR_W   = 5;
  localparam int CTRL_MIN_LSB  = 8;
  localparam int CTRL_MIN_W    = 6;
  localparam int CTRL_SEC_LSB  = 0;
  localparam int CTRL_SEC_W    = 6;

  typedef enum logic [1:0] {
    SC_IDLE = 2'd0,
    SC_CALC = 2'd1,
    SC_SCAN = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    CH_OFF     = 2'd0,
    CH_PENDING = 2'd1,
    CH_HIGH    = 2'd2,
    CH_LOW     = 2'd3
  } ch_state_e;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } tod_t;

  // Packet time is the time of the last PPS, so the next PPS is one second later.
  function automatic tod_t tod_plus_one(input tod_t t);
    tod_t r;
    r = t;
    if (t.sec == 8'd59) begin
      r.sec = 8'd0;
      if (t.min == 8'd59) begin
        r.min  = 8'd0;
        r.hour = (t.hour == 8'd23) ? 8'd0 : t.hour + 8'd1;
      end else begin
        r.min = t.min + 8'd1;
      end
    end else begin
      r.sec = t.sec + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_scheduler_channel.sv
// One schedule entry: OFF -> PENDING -> HIGH <-> LOW -> OFF, timed in
// microsecond ticks, with an optional finite repeat count.
module pulse_channel (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_us_tick,
  input  logic        i_pps,
  input  logic        i_arm,
  input  logic        i_abort,
  input  logic [31:0] i_width_us,
  input  logic [31:0] i_period_us,
  input  logic [15:0] i_count,
  output logic        o_pulse,
  output logic        o_pending,
  output logic        o_active
);
  import pulse_sched_pkg::*;

  ch_state_e   state_q, state_d;
  logic [31:0] us_cnt_q, us_cnt_d;
  logic [15:0] rem_q, rem_d;
  logic        inf_q, inf_d;
  logic        pulse_q, pulse_d;
  logic        pending_q, pending_d;
  logic        active_q, active_d;
  logic [31:0] low_us;
  logic [31:0] us_next;

  assign low_us  = i_period_us - i_width_us;
  assign us_next = us_cnt_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    us_cnt_d = us_cnt_q;
    rem_d    = rem_q;
    inf_d    = inf_q;
    pulse_d  = pulse_q;
    if (i_abort) begin
      state_d  = CH_OFF;
      us_cnt_d = 32'd0;
      pulse_d  = 1'b0;
    end else begin
      case (state_q)
        CH_OFF: begin
          if (i_arm) state_d = CH_PENDING;
        end
        CH_PENDING: begin
          if (i_pps) begin
            us_cnt_d = 32'd0;
            rem_d    = i_count;
            inf_d    = (i_count == 16'd0);
            if (i_width_us == 32'd0) begin
              state_d = CH_OFF;
            end else begin
              state_d = CH_HIGH;
              pulse_d = 1'b1;
            end
          end
        end
        CH_HIGH: begin
          if (i_us_tick) begin
            // >= rather than == so a shrunk width takes effect without wrapping.
            if (us_next >= i_width_us) begin
              us_cnt_d = 32'd0;
              pulse_d  = 1'b0;
              if (!inf_q) rem_d = rem_q - 16'd1;
              if ((!inf_q && rem_q == 16'd1) || (i_period_us <= i_width_us)) begin
                state_d = CH_OFF;
              end else begin
                state_d = CH_LOW;
              end
            end else begin
              us_cnt_d = us_next;
            end
          end
        end
        CH_LOW: begin
          if (i_us_tick) begin
            if (us_next >= low_us) begin
              us_cnt_d = 32'd0;
              state_d  = CH_HIGH;
              pulse_d  = 1'b1;
            end else begin
              us_cnt_d = us_next;
            end
          end
        end
        default: begin
          state_d = CH_OFF;
          pulse_d = 1'b0;
        end
      endcase
    end
    pending_d = (state_d == CH_PENDING);
    active_d  = (state_d == CH_HIGH) || (state_d == CH_LOW);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= CH_OFF;
      us_cnt_q  <= 32'd0;
      rem_q     <= 16'd0;
      inf_q     <= 1'b0;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      us_cnt_q  <= us_cnt_d;
      rem_q     <= rem_d;
      inf_q     <= inf_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  assign o_pulse   = pulse_q;
  assign o_pending = pending_q;
  assign o_active  = active_q;

endmodule

// File: rtl/pulse_scheduler.sv
// Multi-channel PPS-aligned pulse scheduler: config table, time +1 s,
// sequential scanner with one shared comparator, µs prescaler, channels.
module pulse_scheduler #(
  parameter int NUM_CH      = 8,
  parameter int CLKS_PER_US = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pps,
  input  logic              i_thunder_packet_dv,
  input  logic [7:0]        i_thunder_hour,
  input  logic [7:0]        i_thunder_minutes,
  input  logic [7:0]        i_thunder_seconds,
  input  logic              i_cfg_wr,
  input  logic [2:0]        i_cfg_ch,
  input  logic [1:0]        i_cfg_field,
  input  logic [31:0]       i_cfg_data,
  output logic [NUM_CH-1:0] o_pulse,
  output logic [NUM_CH-1:0] o_pending,
  output logic [NUM_CH-1:0] o_active,
  output logic              o_busy,
  output logic              o_scan_overrun
);
  import pulse_sched_pkg::*;

  localparam int              PRE_W    = (CLKS_PER_US > 2) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_US - 1);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_CH - 1);

  logic        en_q     [NUM_CH];
  logic        en_d     [NUM_CH];
  logic [4:0]  hour_q   [NUM_CH];
  logic [4:0]  hour_d   [NUM_CH];
  logic [5:0]  min_q    [NUM_CH];
  logic [5:0]  min_d    [NUM_CH];
  logic [5:0]  sec_q    [NUM_CH];
  logic [5:0]  sec_d    [NUM_CH];
  logic [31:0] width_q  [NUM_CH];
  logic [31:0] width_d  [NUM_CH];
  logic [31:0] period_q [NUM_CH];
  logic [31:0] period_d [NUM_CH];
  logic [15:0] count_q  [NUM_CH];
  logic [15:0] count_d  [NUM_CH];

  logic [NUM_CH-1:0] abort;
  logic [NUM_CH-1:0] arm;
  logic [NUM_CH-1:0] active;

  scan_state_e scan_state_q, scan_state_d;
  logic [2:0]  idx_q, idx_d;
  tod_t        lat_q, lat_d;
  tod_t        tgt_q, tgt_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             us_tick;

  logic       sel_en;
  logic       sel_active;
  logic [4:0] sel_hour;
  logic [5:0] sel_min;
  logic [5:0] sel_sec;
  logic       match;

  // Config table: a CTRL write with en=0 doubles as the channel abort.
  always_comb begin
    abort = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      en_d[i]     = en_q[i];
      hour_d[i]   = hour_q[i];
      min_d[i]    = min_q[i];
      sec_d[i]    = sec_q[i];
      width_d[i]  = width_q[i];
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      if (i_cfg_wr && (int'(i_cfg_ch) == i)) begin
        case (i_cfg_field)
          CFG_CTRL: begin
            en_d[i]   = i_cfg_data[CTRL_EN_BIT];
            hour_d[i] = i_cfg_data[CTRL_HOUR_LSB +: CTRL_HOUR_W];
            min_d[i]  = i_cfg_data[CTRL_MIN_LSB +: CTRL_MIN_W];
            sec_d[i]  = i_cfg_data[CTRL_SEC_LSB +: CTRL_SEC_W];
            abort[i]  = !i_cfg_data[CTRL_EN_BIT];
          end
          CFG_WIDTH:  width_d[i]  = i_cfg_data;
          CFG_PERIOD: period_d[i] = i_cfg_data;
          default:    count_d[i]  = i_cfg_data[15:0];
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        en_q[i]     <= 1'b0;
        hour_q[i]   <= 5'd0;
        min_q[i]    <= 6'd0;
        sec_q[i]    <= 6'd0;
        width_q[i]  <= 32'd0;
        period_q[i] <= 32'd0;
        count_q[i]  <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        en_q[i]     <= en_d[i];
        hour_q[i]   <= hour_d[i];
        min_q[i]    <= min_d[i];
        sec_q[i]    <= sec_d[i];
        width_q[i]  <= width_d[i];
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // Shared comparator: the scan index selects the single entry under test.
  always_comb begin
    sel_en     = en_q[idx_q];
    sel_active = active[idx_q];
    sel_hour   = hour_q[idx_q];
    sel_min    = min_q[idx_q];
    sel_sec    = sec_q[idx_q];
    match = sel_en && !sel_active &&
            ({3'b000, sel_hour} == tgt_q.hour) &&
            ({2'b00, sel_min} == tgt_q.min) &&
            ({2'b00, sel_sec} == tgt_q.sec);
  end

  always_comb begin
    scan_state_d = scan_state_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    tgt_d        = tgt_q;
    arm          = '0;
    case (scan_state_q)
      SC_IDLE: begin
        if (i_thunder_packet_dv) begin
          lat_d        = '{hour: i_thunder_hour, min: i_thunder_minutes, sec: i_thunder_seconds};
          scan_state_d = SC_CALC;
        end
      end
      SC_CALC: begin
        tgt_d        = tod_plus_one(lat_q);
        idx_d        = 3'd0;
        scan_state_d = SC_SCAN;
      end
      SC_SCAN: begin
        for (int i = 0; i < NUM_CH; i++) begin
          arm[i] = match && (int'(idx_q) == i);
        end
        if (idx_q == LAST_IDX) begin
          scan_state_d = SC_IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: scan_state_d = SC_IDLE;
    endcase
    busy_d    = (scan_state_d != SC_IDLE);
    overrun_d = i_thunder_packet_dv && (scan_state_q != SC_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scan_state_q <= SC_IDLE;
      idx_q        <= 3'd0;
      lat_q        <= '0;
      tgt_q        <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      scan_state_q <= scan_state_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      tgt_q        <= tgt_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // PPS restarts the prescaler so every channel's µs grid is PPS-aligned.
  always_comb begin
    us_tick = (pre_q == PRE_MAX);
    pre_d   = (i_pps || us_tick) ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) pre_q <= '0;
    else          pre_q <= pre_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_channel u_channel (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_us_tick   (us_tick),
      .i_pps       (i_pps),
      .i_arm       (arm[g]),
      .i_abort     (abort[g]),
      .i_width_us  (width_q[g]),
      .i_period_us (period_q[g]),
      .i_count     (count_q[g]),
      .o_pulse     (o_pulse[g]),
      .o_pending   (o_pending[g]),
      .o_active    (active[g])
    );
  end

  assign o_active       = active;
  assign o_busy         = busy_q;
  assign o_scan_overrun = overrun_q;

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Multi-channel pulse scheduler placed between the host configuration register bank and the board's timing outputs. It holds a schedule table of NUM_CH entries: target time, width, period and repeat count. On every Thunderbolt time packet, one shared time comparator checks each entry in turn. Every matching entry is armed, and all armed entries fire together on the next PPS strobe, so pulses on all channels stay phase-aligned to PPS.

## Interface
- NUM_CH, 8, number of schedule entries and pulse outputs (1..8)
- CLKS_PER_US, 10, i_clk cycles per microsecond (≥2)
- i_clk  in  1  system clock; one clock domain
- i_rst_n  in  1  reset, synchronous, active-low
- i_pps  in  1  one-cycle PPS strobe, already synchronized to i_clk
- i_thunder_packet_dv  in  1  one-cycle strobe; time fields valid this cycle
- i_thunder_hour / i_thunder_minutes / i_thunder_seconds  in  8 each  time of the most recent PPS
- i_cfg_wr  in  1  config write strobe; no backpressure, accepted every cycle
- i_cfg_ch  in  3  entry index; writes with index ≥ NUM_CH are ignored
- i_cfg_field  in  2  0=CTRL {en[31], hour[20:16], min[13:8], sec[5:0]}, 1=WIDTH_US, 2=PERIOD_US, 3=COUNT[15:0]
- i_cfg_data  in  32  write data
- o_pulse  out  NUM_CH  registered pulse outputs
- o_pending  out  NUM_CH  entry armed, waiting for PPS
- o_active  out  NUM_CH  entry running (HIGH or LOW phase)
- o_busy  out  1  scan in progress
- o_scan_overrun  out  1  one-cycle strobe: packet dropped because a scan was already in progress

## Operation
- Reset (i_rst_n=0 at a clock edge):
  - all outputs 0;
  - table cleared (en=0, fields 0);
  - scanner in IDLE;
  - µs prescaler 0.
- Scanner FSM: IDLE → CALC → SCAN → IDLE.
  - IDLE: on i_thunder_packet_dv, latch the time and go to CALC.
  - CALC (1 cycle): target = latched time + 1 s.
    - sec 59 → 0 carries to min; min 59 → 0 carries to hour; hour 23 → 0.
  - SCAN: index 0..NUM_CH-1, one entry per cycle.
    - Entry matches if en=1, it is not active, and hour/min/sec equal target. A match sets pending[i].
    - After the last index, go to IDLE.
  - o_busy=1 in CALC and SCAN.
  - A packet_dv while busy is dropped and o_scan_overrun pulses.
- Channel FSM, per entry: OFF → PENDING → HIGH ⇄ LOW → OFF.
  - PENDING → HIGH on i_pps. The remaining-count register loads COUNT; COUNT=0 means infinite.
  - HIGH lasts WIDTH_US µs.
  - LOW lasts PERIOD_US − WIDTH_US µs.
  - At the end of HIGH, the remaining count decrements unless infinite. If it reaches 0, the channel goes to OFF; otherwise to LOW.
  - LOW → HIGH at the end of LOW.
  - One-shot: if PERIOD_US ≤ WIDTH_US, the channel goes OFF after the first HIGH.
  - WIDTH_US=0: PENDING → OFF on PPS with no pulse.
- µs timing: a shared prescaler counts 0..CLKS_PER_US-1 and is forced to 0 on every i_pps. Its tick (count = CLKS_PER_US-1) advances the 32-bit per-channel µs counters.
- Config writes:
  - WIDTH, PERIOD, COUNT update immediately. A running channel uses the new values at its next phase boundary.
  - CTRL with en=0 aborts the entry: pending and active cleared, o_pulse low on the next cycle.
  - CTRL with en=1 and a new time does not disturb a running entry.
  - A write in the same cycle as that entry's SCAN compare: the compare uses the pre-write value.
- Simultaneous events:
  - PPS and packet_dv in the same cycle: PPS acts on the pending bits present before this scan. The new scan arms for the following PPS.
  - Abort write and PPS in the same cycle: the abort wins.

## Timing
- Packet to pending: the pending bit for entry i is set at cycle dv+2+i. Scan length is NUM_CH+1 cycles after dv.
- PPS to pulse: o_pulse[i] rises on the edge after the cycle i_pps=1 (1-cycle latency).
- High time is exactly WIDTH_US·CLKS_PER_US cycles, and the pulse period is exactly PERIOD_US·CLKS_PER_US cycles, provided no PPS lands mid-pulse.
- o_pending falls in the same cycle o_pulse rises. o_active is high from that cycle until the channel returns to OFF.

## Structure
- Package pulse_sched_pkg holds:
  - CFG_CTRL/CFG_WIDTH/CFG_PERIOD/CFG_COUNT field codes;
  - scanner state encodings (IDLE, CALC, SCAN);
  - channel state encodings (OFF, PENDING, HIGH, LOW);
  - CTRL bit positions.
- Sub-module pulse_channel: one per entry, via generate. Contains the channel FSM, µs counter, remaining-count register and o_pulse flop. Inputs: us_tick, pps, arm, abort.
- The top level holds the config table, the time +1 s adder with wrap, the scanner, the shared comparator and the prescaler.

## Test plan
- Entry 2: CTRL {en, 10:15:30}, WIDTH=5, PERIOD=0, COUNT=1. Packet 10:15:29, then PPS → pending[2] at dv+4; o_pulse[2] high exactly 50 cycles after PPS+1; one pulse only.
- Wrap: entry 0 at 00:00:00, packet 23:59:59, PPS → entry 0 fires. Entry 1 at 24:00:00 → never fires.
- Periodic: WIDTH=3, PERIOD=10, COUNT=3 → three 30-cycle highs, rising edges 100 cycles apart, then o_active=0. COUNT=0 → still pulsing after 10 periods.
- Overrun: second packet_dv 2 cycles after the first → o_scan_overrun strobes once; pending set from the first packet only.
- Abort: CTRL en=0 written mid-HIGH → o_pulse low next cycle, o_active=0. Reset asserted mid-pulse → all outputs 0 on the next edge.
- Simultaneous: PPS in the same cycle as packet_dv with entry 4 already pending → entry 4 fires now. An entry matched by this packet fires on the next PPS.
